// File: rtl/proc_io_bridge_pkg.sv
// -----------------------------------------------------------------------------
// proc_io_bridge_pkg
// Shared constants and helpers for the processor I/O bridge.
//   DW_DEFAULT    : default data word width
//   DEPTH_DEFAULT : default per-channel FIFO depth (power of two, >= 2)
//   NUM_CH        : fixed number of bridged channels
//   clog2()       : pointer width for a FIFO of a given depth
// -----------------------------------------------------------------------------
package proc_io_bridge_pkg;

    localparam int DW_DEFAULT    = 32;
    localparam int DEPTH_DEFAULT = 4;
    localparam int NUM_CH        = 3;

    // Number of bits needed to address 'value' entries (value >= 2).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : proc_io_bridge_pkg

// File: rtl/proc_io_bridge_io_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
// Single-clock FIFO used for every bridge buffer. No bypass path: a word
// pushed in a cycle is only visible at the head from the following cycle.
// Pushes while full and pops while empty are ignored here; the parent
// decides whether those events are errors.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   push     : write wdata this cycle (ignored when full)
//   pop      : discard the head this cycle (ignored when empty)
//   wdata    : word to write
//   head     : oldest stored word, forced to 0 when empty
//   full     : DEPTH words stored
//   empty    : no words stored
// -----------------------------------------------------------------------------
module io_fifo
    import proc_io_bridge_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    // One extra bit so that occupancy can reach DEPTH.
    logic [AW:0]   count;

    logic do_push;
    logic do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule : io_fifo

// File: rtl/proc_io_bridge.sv
// -----------------------------------------------------------------------------
// proc_io_bridge
// Three-channel buffer between a processor's I/O ports and external streams.
// Each channel k has an input FIFO (external source -> processor) and an
// output FIFO (processor -> external sink).
//
// Handshake semantics (src_* and snk_*): a word transfers on every rising
// edge where valid and ready are both high; valid never depends on ready,
// and data/valid stay stable while valid is high and ready is low.
//
// Ports:
//   clk, rst_geral         : clock and synchronous active-high reset
//   proc_req_in[2:0]       : one-hot read request, one word per cycle
//   proc_in0..2            : input FIFO heads (0 when empty)
//   proc_out_en[2:0]       : write strobes; the word follows one cycle later
//   proc_out0..2           : processor output words
//   src_data/valid/ready   : external input streams, channel k in slice k
//   snk_data/valid/ready   : external output streams, channel k in slice k
//   underflow, overflow    : sticky per-channel error flags
//   clr_status             : clears both flag vectors
// -----------------------------------------------------------------------------
module proc_io_bridge
    import proc_io_bridge_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_geral,
    input  logic [NUM_CH-1:0]    proc_req_in,
    output logic [DW-1:0]        proc_in0,
    output logic [DW-1:0]        proc_in1,
    output logic [DW-1:0]        proc_in2,
    input  logic [NUM_CH-1:0]    proc_out_en,
    input  logic [DW-1:0]        proc_out0,
    input  logic [DW-1:0]        proc_out1,
    input  logic [DW-1:0]        proc_out2,
    input  logic [NUM_CH*DW-1:0] src_data,
    input  logic [NUM_CH-1:0]    src_valid,
    output logic [NUM_CH-1:0]    src_ready,
    output logic [NUM_CH*DW-1:0] snk_data,
    output logic [NUM_CH-1:0]    snk_valid,
    input  logic [NUM_CH-1:0]    snk_ready,
    output logic [NUM_CH-1:0]    underflow,
    output logic [NUM_CH-1:0]    overflow,
    input  logic                 clr_status
);

    logic [NUM_CH-1:0] in_full;
    logic [NUM_CH-1:0] in_empty;
    logic [NUM_CH-1:0] in_push;
    logic [NUM_CH-1:0] in_pop;
    logic [DW-1:0]     in_head [NUM_CH];

    logic [NUM_CH-1:0] out_full;
    logic [NUM_CH-1:0] out_empty;
    logic [NUM_CH-1:0] out_pop;
    logic [DW-1:0]     out_head [NUM_CH];
    logic [DW-1:0]     out_word [NUM_CH];

    logic [NUM_CH-1:0] en_d;
    logic              req_onehot;
    logic [NUM_CH-1:0] req_sel;
    logic [NUM_CH-1:0] underflow_set;
    logic [NUM_CH-1:0] overflow_set;

    assign out_word[0] = proc_out0;
    assign out_word[1] = proc_out1;
    assign out_word[2] = proc_out2;

    // ---------------- processor read side ----------------
    // Requests with zero or several bits set are ignored entirely.
    always_comb begin
        req_onehot = 1'b0;
        case (proc_req_in)
            3'b001, 3'b010, 3'b100: req_onehot = 1'b1;
            default:                req_onehot = 1'b0;
        endcase
    end

    assign req_sel       = req_onehot ? proc_req_in : '0;
    assign in_pop        = req_sel & ~in_empty;
    assign underflow_set = req_sel & in_empty;

    assign src_ready = rst_geral ? '0 : ~in_full;
    assign in_push   = src_valid & src_ready;

    assign proc_in0 = in_head[0];
    assign proc_in1 = in_head[1];
    assign proc_in2 = in_head[2];

    // ---------------- processor write side ----------------
    // The processor registers its output, so the strobe is delayed one cycle
    // to line up with the word it qualifies.
    always_ff @(posedge clk) begin
        if (rst_geral) begin
            en_d <= '0;
        end else begin
            en_d <= proc_out_en;
        end
    end

    // A push into a full FIFO is dropped even if the sink pops in the same
    // cycle; the FIFO sees full and ignores the push.
    assign overflow_set = en_d & out_full;
    assign snk_valid    = ~out_empty;
    assign out_pop      = snk_valid & snk_ready;

    // ---------------- sticky status ----------------
    // A set event in the same cycle as clr_status leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst_geral) begin
            underflow <= '0;
            overflow  <= '0;
        end else begin
            underflow <= (clr_status ? '0 : underflow) | underflow_set;
            overflow  <= (clr_status ? '0 : overflow)  | overflow_set;
        end
    end

    // ---------------- FIFO instances ----------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        io_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_in_fifo (
            .clk   (clk),
            .rst   (rst_geral),
            .push  (in_push[k]),
            .pop   (in_pop[k]),
            .wdata (src_data[DW*k +: DW]),
            .head  (in_head[k]),
            .full  (in_full[k]),
            .empty (in_empty[k])
        );

        io_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_out_fifo (
            .clk   (clk),
            .rst   (rst_geral),
            .push  (en_d[k]),
            .pop   (out_pop[k]),
            .wdata (out_word[k]),
            .head  (out_head[k]),
            .full  (out_full[k]),
            .empty (out_empty[k])
        );

        assign snk_data[DW*k +: DW] = out_head[k];
    end

endmodule : proc_io_bridge

// File: doc/proc_io_bridge.md
PROC_IO_BRIDGE -- requirements
Module: proc_io_bridge

Interface
REQ-001 SHALL have parameter DW, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 4, per-channel FIFO depth (power of two, >=2).
REQ-003 SHALL have a fixed channel count of 3; channel k occupies bit k of 3-bit vectors and bits [DW*k+DW-1:DW*k] of packed data.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_geral  in  1  reset, synchronous and active-high.
REQ-006 proc_req_in  in  3  processor read-request, one-hot; 1 cycle per word.
REQ-007 proc_in0, proc_in1, proc_in2  out  DW each  words presented to processor input ports.
REQ-008 proc_out_en  in  3  processor write strobes, one-hot.
REQ-009 proc_out0, proc_out1, proc_out2  in  DW each  registered processor outputs, valid 1 cycle after strobe.
REQ-010 src_data  in  3*DW  external input words; src_valid  in  3; src_ready  out  3.
REQ-011 snk_data  out  3*DW  external output words; snk_valid  out  3; snk_ready  in  3.
REQ-012 underflow  out  3  sticky read-while-empty flags; overflow  out  3  sticky write-while-full flags.
REQ-013 clr_status  in  1  clears underflow and overflow.

Function
REQ-014 SHALL hold one input FIFO and one output FIFO per channel, each DEPTH words, occupancy 0..DEPTH, pointers wrapping modulo DEPTH.
REQ-015 Input push: src_valid[k] & src_ready[k]; src_ready[k] = input FIFO k not full and rst_geral low.
REQ-016 proc_inK SHALL equal input FIFO k head when non-empty, else 0; combinational from stored state, zero added latency.
REQ-017 Pop of input FIFO k SHALL occur on each cycle proc_req_in == one-hot bit k and FIFO k non-empty; request held N cycles pops N words.
REQ-018 Request to empty input FIFO k: no pop, proc_inK = 0, underflow[k] set next cycle.
REQ-019 proc_req_in with 0 or >=2 bits set: no pop, no flag change.
REQ-020 Simultaneous push and pop on a non-empty input FIFO: both take effect, occupancy unchanged; on empty FIFO push is stored, pop is underflow (no bypass).
REQ-021 proc_out_en SHALL be delayed one cycle (en_d); on en_d[k], proc_outK SHALL be pushed into output FIFO k.
REQ-022 All set bits of en_d push independently (non-one-hot allowed).
REQ-023 Push to full output FIFO k: word dropped, overflow[k] set next cycle; a same-cycle sink pop does not create room.
REQ-024 snk_valid[k] = output FIFO k non-empty; snk_data slice k = head; pop on snk_valid[k] & snk_ready[k]; head stable while valid & !ready.
REQ-025 Flags SHALL stay set until clr_status; a set event in the clr_status cycle wins.
REQ-026 Latency: src word accepted at edge N visible on proc_inK after edge N; proc_out_en at cycle N -> snk_valid high after edge N+2.

Reset
REQ-027 While rst_geral high at an edge: all FIFOs empty, pointers 0, en_d = 0, underflow = overflow = 0.
REQ-028 During reset cycles src_ready = 0; after release src_ready = 3'b111, snk_valid = 0, proc_in0..2 = 0.
REQ-029 Reset mid-operation SHALL discard all buffered words; storage arrays need not be reset.

Structure
REQ-030 Shared package SHALL hold DW default, DEPTH default, channel count 3 and pointer-width function clog2(DEPTH).
REQ-031 One sub-module io_fifo (sync FIFO, push/pop/full/empty/head, no bypass) SHALL be instantiated six times.

Verification
REQ-032 Push 0x11,0x22 on src ch0, then proc_req_in=001 two cycles -> proc_in0 shows 0x11 then 0x22, then 0; underflow=000.
REQ-033 proc_req_in=010 with ch1 empty -> proc_in1=0, underflow=010 next cycle; clr_status -> 000.
REQ-034 proc_out_en=100, next cycle proc_out2=0xDEADBEEF, snk_ready=0 -> snk_valid[2] high 2 cycles after strobe, data stable 0xDEADBEEF until snk_ready.
REQ-035 Five strobes on ch0 with snk_ready=0, DEPTH=4 -> 4 words kept in order, overflow=001, src_ready unaffected.
REQ-036 ch2 holds 3 words, rst_geral 1 cycle mid-stream -> snk_valid=000, src_ready=000 during reset then 111, next proc request underflows.
REQ-037 proc_req_in=011 with ch0/ch1 non-empty -> no pop, occupancies unchanged, no flags.
